// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access sizes, FSM states,
// lane widths and the alignment-fault helper.
package mau_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_WAIT = 3'd1,
    RMW_READ  = 3'd2,
    RMW_WRITE = 3'd3,
    RESP      = 3'd4
  } mau_state_e;

  // High for a misaligned half/word access or the illegal size encoding.
  function automatic logic size_fault(input size_e size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return (offset != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: load-lane extraction/extension and, when
// MAU_SUBWORD_STORE_EN is defined, merging a store lane into a read word.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  size_e                 size,
  input  logic                  is_unsigned,
`ifdef MAU_SUBWORD_STORE_EN
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] merged_data,
`endif
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  assign byte_s = rdata[{offset, 3'b000} +: BYTE_W];
  assign half_s = rdata[{offset[1], 4'b0000} +: HALF_W];

  // Load lane select with sign or zero extension
  always_comb begin
    load_data = {DATA_WIDTH{1'b0}};
    case (size)
      SIZE_BYTE: begin
        if (is_unsigned) begin
          load_data = {{(DATA_WIDTH-BYTE_W){1'b0}}, byte_s};
        end else begin
          load_data = {{(DATA_WIDTH-BYTE_W){byte_s[BYTE_W-1]}}, byte_s};
        end
      end
      SIZE_HALF: begin
        if (is_unsigned) begin
          load_data = {{(DATA_WIDTH-HALF_W){1'b0}}, half_s};
        end else begin
          load_data = {{(DATA_WIDTH-HALF_W){half_s[HALF_W-1]}}, half_s};
        end
      end
      SIZE_WORD: load_data = rdata;
      default:   load_data = {DATA_WIDTH{1'b0}};
    endcase
  end

`ifdef MAU_SUBWORD_STORE_EN
  // Overlay the right-aligned store lane onto the word read back from memory
  always_comb begin
    merged_data = rdata;
    case (size)
      SIZE_BYTE: merged_data[{offset, 3'b000} +: BYTE_W]    = wdata[BYTE_W-1:0];
      SIZE_HALF: merged_data[{offset[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default:   merged_data = wdata;
    endcase
  end
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a dual-port word memory.
// Sub-word stores use read-modify-write only when MAU_SUBWORD_STORE_EN is defined.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WORDS  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(NUM_WORDS);

  mau_state_e            state_r, state_nxt_s;
  size_e                 size_s, size_r;
  logic [ADDR_WIDTH-1:0] index_s;
  logic                  req_err_s, accept_s;
  logic [1:0]            offset_r;
  logic                  unsigned_r, err_r;
  logic [DATA_WIDTH-1:0] load_data_s;
`ifdef MAU_SUBWORD_STORE_EN
  logic [ADDR_WIDTH-1:0] index_r;
  logic [DATA_WIDTH-1:0] wdata_r, merged_s, merged_r;
`endif

  assign size_s   = size_e'(req_size);
  assign index_s  = req_addr >> 2'd2;
  assign accept_s = req_valid && req_ready;

`ifdef MAU_SUBWORD_STORE_EN
  assign req_err_s = size_fault(size_s, req_addr[1:0]) || (index_s >= WORD_LIMIT);
`else
  assign req_err_s = size_fault(size_s, req_addr[1:0]) || (index_s >= WORD_LIMIT) ||
                     (req_we && (size_s != SIZE_WORD));
`endif

  mau_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .rdata       (mem_rdata),
    .offset      (offset_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
`ifdef MAU_SUBWORD_STORE_EN
    .wdata       (wdata_r),
    .merged_data (merged_s),
`endif
    .load_data   (load_data_s)
  );

  // State register and capture of the accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      offset_r   <= 2'b00;
      size_r     <= SIZE_BYTE;
      unsigned_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        offset_r   <= req_addr[1:0];
        size_r     <= size_s;
        unsigned_r <= req_unsigned;
        err_r      <= req_err_s;
      end
    end
  end

`ifdef MAU_SUBWORD_STORE_EN
  // Store target and data capture; merged word is registered during RMW_READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r  <= {DATA_WIDTH{1'b0}};
      merged_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        index_r <= index_s;
        wdata_r <= req_wdata;
      end
      if (state_r == RMW_READ) begin
        merged_r <= merged_s;
      end
    end
  end
`endif

  // Next-state and port drive; everything is held low while rst is high
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = {DATA_WIDTH{1'b0}};
    mem_wen     = 1'b0;
    mem_waddr   = {ADDR_WIDTH{1'b0}};
    mem_wdata   = {DATA_WIDTH{1'b0}};
    mem_ren     = 1'b0;
    mem_raddr   = {ADDR_WIDTH{1'b0}};
    if (rst) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          req_ready = 1'b1;
          if (!req_valid) begin
            state_nxt_s = IDLE;
          end else if (req_err_s) begin
            state_nxt_s = RESP;
          end else if (!req_we) begin
            mem_ren     = 1'b1;
            mem_raddr   = index_s;
            state_nxt_s = LOAD_WAIT;
          end else if (size_s == SIZE_WORD) begin
            mem_wen     = 1'b1;
            mem_waddr   = index_s;
            mem_wdata   = req_wdata;
            state_nxt_s = RESP;
          end else begin
`ifdef MAU_SUBWORD_STORE_EN
            mem_ren     = 1'b1;
            mem_raddr   = index_s;
            state_nxt_s = RMW_READ;
`else
            state_nxt_s = RESP;
`endif
          end
        end
        LOAD_WAIT: begin
          resp_valid  = 1'b1;
          resp_rdata  = load_data_s;
          state_nxt_s = IDLE;
        end
`ifdef MAU_SUBWORD_STORE_EN
        RMW_READ: begin
          state_nxt_s = RMW_WRITE;
        end
        RMW_WRITE: begin
          mem_wen     = 1'b1;
          mem_waddr   = index_r;
          mem_wdata   = merged_r;
          state_nxt_s = RESP;
        end
`endif
        RESP: begin
          resp_valid  = 1'b1;
          resp_err    = err_r;
          state_nxt_s = IDLE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address and word-index width.
REQ-003 SHALL have parameter NUM_WORDS, default 128, memory depth in words.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  pipeline access request.
REQ-007 SHALL have port req_ready  out  1  unit can accept a request this cycle.
REQ-008 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-010 SHALL have port req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 SHALL have port req_addr  in  ADDR_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-013 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-014 SHALL have port resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  out  1  access faulted; qualified by resp_valid.
REQ-016 SHALL have ports mem_wen out 1, mem_waddr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_ren out 1, mem_raddr out ADDR_WIDTH, mem_rdata in DATA_WIDTH, driving the dual-port word memory (registered read, one-cycle latency).

Function
REQ-017 SHALL implement states IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request when req_valid && req_ready; word index = req_addr >> 2.
REQ-019 SHALL flag an error when: half with addr[0]=1, word with addr[1:0]!=0, size 11, or word index >= NUM_WORDS.
REQ-020 SHALL, on an error request, assert neither mem_wen nor mem_ren, go to RESP, and pulse resp_valid=1, resp_err=1, resp_rdata=0 the next cycle.
REQ-021 SHALL issue a load as mem_ren=1, mem_raddr=index in the accept cycle, go to LOAD_WAIT, and in LOAD_WAIT drive resp_valid=1 with the byte/half lane selected by addr[1:0] and extended per req_unsigned; load latency is 1 cycle.
REQ-022 SHALL issue a word store as mem_wen=1, mem_waddr=index, mem_wdata=req_wdata in the accept cycle, then pulse resp_valid in RESP.
REQ-023 SHALL handle a sub-word store as read-modify-write: accept cycle mem_ren (RMW_READ), next cycle merge wdata lane into mem_rdata and assert mem_wen (RMW_WRITE), then resp_valid in RESP; total 3 cycles.
REQ-024 SHALL register address, size, unsigned flag and wdata at acceptance; inputs are ignored outside IDLE.
REQ-025 SHALL return to IDLE after any resp_valid pulse; a new request is accepted at the earliest the cycle after the pulse.
REQ-026 SHALL assert mem_wen at most one cycle per request and never for error requests.
REQ-027 SHALL drive mem_ren=0 and mem_wen=0 in every cycle not listed above.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_ren=0, mem_waddr=0, mem_raddr=0, mem_wdata=0.
REQ-029 SHALL, on reset mid-operation, abandon the access: no pending RMW write and no resp_valid after reset release.
REQ-030 SHALL raise req_ready the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with MAU_SUBWORD_STORE_EN defined, implement the RMW path of REQ-023.
REQ-032 SHALL, without MAU_SUBWORD_STORE_EN, treat byte/half stores as errors per REQ-020; RMW_READ/RMW_WRITE are not built; sub-word loads are unaffected.

Structure
REQ-033 SHALL take size encodings, state enumeration and lane-width constants from shared package mau_pkg.
REQ-034 SHALL place lane extraction/extension and store-lane merge in combinational sub-module mau_lane_align.

Verification
REQ-035 Word 0x8 holds 0x80FF_7F01; load byte addr 0x9 signed -> resp_valid one cycle after accept, resp_rdata 0x0000_007F; addr 0xB signed -> 0xFFFF_FF80.
REQ-036 Half store 0xBEEF to addr 0x12 over word 0x1111_1111 -> single mem_wen at word 4 with 0xBEEF_1111, resp_valid 3 cycles after accept.
REQ-037 Word load addr 0x6 -> resp_err=1, resp_rdata=0, no mem_ren/mem_wen asserted.
REQ-038 Word load addr 0x200 (NUM_WORDS=128) -> resp_err=1, no memory access.
REQ-039 rst pulsed in RMW_WRITE state's preceding cycle (RMW_READ) -> no mem_wen, no resp_valid, req_ready=1 after release, memory word unchanged.
REQ-040 Without MAU_SUBWORD_STORE_EN: byte store addr 0x4 -> resp_err=1, memory unchanged; byte load addr 0x4 succeeds.
